// File: rtl/mcp3008_pkg.sv
// mcp3008_pkg: shared types and constants for the MCP3008 round-robin scanner.
//   state_t  - scanner FSM states
//   NUM_CH   - number of ADC channels
//   BIT_*    - SPI frame bit positions (SCLK period index within a frame)
//   cmd_bit  - DIN value for a given frame bit and channel
package mcp3008_pkg;

   localparam int unsigned NUM_CH     = 8;
   localparam int unsigned CH_W       = 3;
   localparam int unsigned DATA_W     = 10;
   localparam int unsigned BIT_SAMPLE = 5;
   localparam int unsigned BIT_NULL   = 6;
   localparam int unsigned BIT_MSB    = 7;
   localparam int unsigned BIT_LAST   = 16;
   localparam int unsigned FRAME_BITS = 17;
   localparam int unsigned BIT_W      = $clog2(FRAME_BITS + 1);
   localparam int unsigned HALF_W     = $clog2(2 * FRAME_BITS);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_CAPTURE,
      ST_GAP
   } state_t;

   // Command word: start, SGL, D2, D1, D0, then zeros for the rest of the frame.
   function automatic logic cmd_bit(input logic [BIT_W-1:0] idx, input logic [CH_W-1:0] ch);
      logic b;
      b = 1'b0;
      if (idx < BIT_W'(BIT_SAMPLE)) begin
         case (idx)
            BIT_W'(0), BIT_W'(1): b = 1'b1;
            BIT_W'(2):            b = ch[2];
            BIT_W'(3):            b = ch[1];
            default:              b = ch[0];
         endcase
      end
      return b;
   endfunction

endpackage

// File: rtl/mcp3008_tick.sv
// mcp3008_tick: SCLK half-period timer.
//   clk, rst_n - clock, async active-low reset
//   run        - count while high; counter held at 0 while low
//   tick       - high on the last clk cycle of each half-period (combinational)
module mcp3008_tick
   import mcp3008_pkg::*;
#(
   parameter int unsigned CLK_DIV = 25
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   output logic tick
);

   localparam int unsigned CNT_W = 8;

   logic [CNT_W-1:0] cnt;

   assign tick = run && (cnt == CNT_W'(CLK_DIV - 1));

   // Free-running divider, restarted whenever the scanner is not running.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (!run || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/mcp3008_scanner.sv
// mcp3008_scanner: round-robin SPI master for the MCP3008, single-ended ch 0..7.
//   clk, rst_n          - clock, async active-low reset
//   enable              - scan while high; a running frame always completes
//   AD_CLK, CS, DIN     - ADC SPI pins (mode 0), DOUT - ADC data (async)
//   ch_data             - per-channel result bank
//   sample_data/_ch     - latest result and its channel
//   sample_valid        - one-cycle strobe per result; scan_done with channel 7
//   null_err            - one-cycle strobe when the null bit reads 1
// Build option: define MCP3008_AVG_EN to store a rounded running average
// (first capture per channel after reset is stored raw).
module mcp3008_scanner
   import mcp3008_pkg::*;
#(
   parameter int unsigned CLK_DIV    = 25,
   parameter int unsigned GAP_HALVES = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           enable,
   output logic                           AD_CLK,
   output logic                           CS,
   output logic                           DIN,
   input  logic                           DOUT,
   output logic [NUM_CH-1:0][DATA_W-1:0]  ch_data,
   output logic [DATA_W-1:0]              sample_data,
   output logic [CH_W-1:0]                sample_ch,
   output logic                           sample_valid,
   output logic                           scan_done,
   output logic                           null_err
);

   localparam int unsigned GAP_W = 4;
   localparam int unsigned SUM_W = DATA_W + 1;

   state_t               state, next_state;
   logic                 tick, run, sample_edge;
   logic [HALF_W-1:0]    half_cnt;
   logic [GAP_W-1:0]     gap_cnt;
   logic [BIT_W-1:0]     bit_idx;
   logic                 dout_meta, dout_s;
   logic [DATA_W-1:0]    shreg, store_val;
   logic [CH_W-1:0]      ch;

   // Timer restarts in CAPTURE so GAP gets whole half-periods.
   assign run         = (state != ST_IDLE) && (state != ST_CAPTURE);
   assign bit_idx     = half_cnt[HALF_W-1:1];
   assign sample_edge = (state == ST_SHIFT) && tick && AD_CLK;

   mcp3008_tick #(.CLK_DIV(CLK_DIV)) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .run   (run),
      .tick  (tick)
   );

`ifdef MCP3008_AVG_EN
   logic [NUM_CH-1:0] seen;
   logic [SUM_W-1:0]  avg_sum;

   assign avg_sum   = {1'b0, ch_data[ch]} + {1'b0, shreg} + SUM_W'(1);
   assign store_val = seen[ch] ? DATA_W'(avg_sum >> 1) : shreg;

   // Marks channels that already hold a value to average against.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seen <= '0;
      end else if (state == ST_CAPTURE) begin
         seen[ch] <= 1'b1;
      end
   end
`else
   assign store_val = shreg;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic.
   always_comb begin
      next_state = state;
      unique case (state)
         ST_IDLE:    if (enable) next_state = ST_SETUP;
         ST_SETUP:   if (tick) next_state = ST_SHIFT;
         ST_SHIFT:   if (sample_edge && (bit_idx == BIT_W'(BIT_LAST))) next_state = ST_CAPTURE;
         ST_CAPTURE: next_state = ST_GAP;
         ST_GAP:     if (tick && (gap_cnt == GAP_W'(GAP_HALVES - 1)))
                        next_state = enable ? ST_SETUP : ST_IDLE;
         default:    next_state = ST_IDLE;
      endcase
   end

   // DOUT synchronizer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout_meta <= 1'b0;
         dout_s    <= 1'b0;
      end else begin
         dout_meta <= DOUT;
         dout_s    <= dout_meta;
      end
   end

   // Half-period counters for SHIFT and GAP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         half_cnt <= '0;
         gap_cnt  <= '0;
      end else begin
         if (state != ST_SHIFT) half_cnt <= '0;
         else if (tick)         half_cnt <= half_cnt + HALF_W'(1);
         if (state != ST_GAP)   gap_cnt <= '0;
         else if (tick)         gap_cnt <= gap_cnt + GAP_W'(1);
      end
   end

   // SPI pins; CS follows next_state so it changes with the state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         AD_CLK <= 1'b0;
         CS     <= 1'b1;
         DIN    <= 1'b0;
      end else begin
         CS <= !((next_state == ST_SETUP) || (next_state == ST_SHIFT));
         if ((state == ST_SHIFT) && tick) AD_CLK <= !AD_CLK;
         if (next_state == ST_SETUP) begin
            DIN <= 1'b1;
         end else if (sample_edge) begin
            // falling edge opens the next bit's low phase
            DIN <= cmd_bit(bit_idx + BIT_W'(1), ch);
         end else if ((next_state == ST_GAP) || (next_state == ST_IDLE)) begin
            DIN <= 1'b0;
         end
      end
   end

   // Data shift-in, capture into the bank and strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg        <= '0;
         ch           <= '0;
         ch_data      <= '0;
         sample_data  <= '0;
         sample_ch    <= '0;
         sample_valid <= 1'b0;
         scan_done    <= 1'b0;
         null_err     <= 1'b0;
      end else begin
         sample_valid <= 1'b0;
         scan_done    <= 1'b0;
         null_err     <= 1'b0;
         if (sample_edge) begin
            if (bit_idx == BIT_W'(BIT_NULL)) null_err <= dout_s;
            if (bit_idx >= BIT_W'(BIT_MSB))  shreg <= {shreg[DATA_W-2:0], dout_s};
         end
         if (state == ST_CAPTURE) begin
            ch_data[ch]  <= store_val;
            sample_data  <= store_val;
            sample_ch    <= ch;
            sample_valid <= 1'b1;
            scan_done    <= (ch == CH_W'(NUM_CH - 1));
            ch           <= ch + CH_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_mcp3008_scanner.sv
// tb_mcp3008_scanner: scoreboard bench for mcp3008_scanner with an MCP3008 pin model.
module tb_mcp3008_scanner;
   import mcp3008_pkg::*;

   localparam int PER = 20;

   typedef struct packed {
      logic [2:0] ch;
      logic [9:0] data;
      logic       last;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n, enable, AD_CLK, CS, DIN, DOUT;
   logic [NUM_CH-1:0][DATA_W-1:0] ch_data;
   logic [DATA_W-1:0] sample_data;
   logic [CH_W-1:0]   sample_ch;
   logic sample_valid, scan_done, null_err;

   always #10 clk = ~clk;

   mcp3008_scanner #(.CLK_DIV(25), .GAP_HALVES(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable       (enable),
      .AD_CLK       (AD_CLK),
      .CS           (CS),
      .DIN          (DIN),
      .DOUT         (DOUT),
      .ch_data      (ch_data),
      .sample_data  (sample_data),
      .sample_ch    (sample_ch),
      .sample_valid (sample_valid),
      .scan_done    (scan_done),
      .null_err     (null_err)
   );

   int total = 0;
   int bad   = 0;
   int n_samples = 0, n_scan = 0, n_null = 0;

   exp_t sb_q[$];
   logic [9:0]  model_val [8];
   logic [9:0]  frame_vals [8];
   logic [9:0]  sh_bank [8];
   bit          sh_seen [8];
   int          null_ch = -1, frame_null = -1;
   int          exp_ch = 0, frame_ch = 0, dec_ch = 0, bitcnt = 0;
   logic [16:0] din_bits;
   time         t_fall = 0, t_rise0 = 0, t_rise1 = 0;
   bit          have_prev = 1'b0, chk_spacing = 1'b0, null_exp = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Frame start: snapshot the model and push the expected capture.
   always @(negedge CS) begin
      exp_t e;
      logic [9:0] raw;
      if (chk_spacing && have_prev) check("frame_spacing", int'(($time - t_fall) / PER), 976);
      have_prev  = 1'b1;
      t_fall     = $time;
      bitcnt     = 0;
      din_bits   = '0;
      frame_vals = model_val;
      frame_null = null_ch;
      frame_ch   = exp_ch;
      null_exp   = (null_ch == exp_ch);
      raw        = model_val[exp_ch];
`ifdef MCP3008_AVG_EN
      if (sh_seen[exp_ch]) raw = 10'(({1'b0, sh_bank[exp_ch]} + {1'b0, raw} + 11'd1) >> 1);
      sh_seen[exp_ch] = 1'b1;
`endif
      sh_bank[exp_ch] = raw;
      e.ch   = 3'(exp_ch);
      e.data = raw;
      e.last = (exp_ch == 7);
      sb_q.push_back(e);
      exp_ch = (exp_ch + 1) % 8;
   end

   // ADC model: latch DIN and present the bit for this SCLK period.
   always @(posedge AD_CLK) begin
      if (CS == 1'b0 && bitcnt < 17) begin
         din_bits[bitcnt] = DIN;
         if (bitcnt == 0) t_rise0 = $time;
         if (bitcnt == 1) t_rise1 = $time;
         if (bitcnt == 4) dec_ch = int'({din_bits[2], din_bits[3], din_bits[4]});
         if (bitcnt == 6)      DOUT = (frame_null == dec_ch);
         else if (bitcnt >= 7) DOUT = frame_vals[dec_ch][16 - bitcnt];
         else                  DOUT = 1'b0;
         bitcnt++;
      end
   end

   // Frame end: command word and pin timing.
   always @(posedge CS) begin
      if (bitcnt == 17) begin
         check("din_start_sgl", int'(din_bits[1:0]), 3);
         check("din_channel", dec_ch, frame_ch);
         check("din_tail_zero", int'(din_bits[16:5]), 0);
         check("sclk_period", int'((t_rise1 - t_rise0) / PER), 50);
         check("cs_low_time", int'(($time - t_fall) / PER), 875);
      end
      DOUT = 1'b0;
   end

   // Monitor: pop and compare on every strobe.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (sample_valid) begin
            n_samples++;
            if (scan_done) n_scan++;
            if (sb_q.size() == 0) begin
               check("sb_unexpected_sample", 1, 0);
            end else begin
               e = sb_q.pop_front();
               check("sample_ch", int'(sample_ch), int'(e.ch));
               check("sample_data", int'(sample_data), int'(e.data));
               check("ch_data_bank", int'(ch_data[e.ch]), int'(e.data));
               check("scan_done", int'(scan_done), int'(e.last));
               check("valid_latency", int'(($time - PER / 2 - t_fall) / PER), 876);
            end
         end else if (scan_done) begin
            check("scan_done_alone", 1, 0);
         end
         if (null_err) begin
            n_null++;
            check("null_err_frame", int'(null_exp), 1);
            check("null_err_cs_low", int'(CS), 0);
         end
      end
   end

   task automatic wait_samples(input int n, input string what);
      int target = n_samples + n;
      int cnt = 0;
      while (n_samples < target && cnt < n * 1100 + 2000) begin
         @(negedge clk);
         cnt++;
      end
      check(what, int'(n_samples >= target), 1);
   endtask

   task automatic wait_bits(input int nb, input string what);
      int cnt = 0;
      while (!(CS == 1'b0 && bitcnt >= nb) && cnt < 4000) begin
         @(negedge clk);
         cnt++;
      end
      check(what, int'(CS == 1'b0 && bitcnt >= nb), 1);
   endtask

   initial begin
      int s0, cs_low;
      rst_n  = 1'b1;
      enable = 1'b0;
      DOUT   = 1'b0;
      for (int i = 0; i < 8; i++) begin
         model_val[i] = 10'h2A5;
         sh_bank[i]   = '0;
         sh_seen[i]   = 1'b0;
      end
      #5 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_cs", int'(CS), 1);
      check("rst_sclk", int'(AD_CLK), 0);
      check("rst_din", int'(DIN), 0);
      check("rst_strobes", int'({sample_valid, scan_done, null_err}), 0);
      check("rst_sample_data", int'(sample_data), 0);
      check("rst_sample_ch", int'(sample_ch), 0);
      check("rst_bank_zero", int'(ch_data != '0), 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_cs_after_rst", int'(CS), 1);

      // Full scan with a constant value.
      enable = 1'b1;
      wait_samples(8, "wait_scan1");
      enable = 1'b0;
      check("scan_done_count", n_scan, 1);
      for (int i = 0; i < 8; i++) check("bank_2a5", int'(ch_data[i]), 'h2A5);
      repeat (300) @(negedge clk);

      // Per-channel values, continuous frame spacing.
      for (int i = 0; i < 8; i++) model_val[i] = 10'(100 * (i + 1));
      have_prev   = 1'b0;
      chk_spacing = 1'b1;
      enable      = 1'b1;
      wait_samples(8, "wait_scan2");
      enable      = 1'b0;
      chk_spacing = 1'b0;
`ifdef MCP3008_AVG_EN
      check("bank_ch5", int'(ch_data[5]), 639);
`else
      check("bank_ch5", int'(ch_data[5]), 600);
`endif
      repeat (300) @(negedge clk);

      // Drop enable in bit 3 of ch 2's frame.
      enable = 1'b1;
      wait_samples(2, "wait_ch0_ch1");
      wait_bits(4, "wait_ch2_bit3");
      enable = 1'b0;
      wait_samples(1, "wait_ch2");
      s0 = n_samples;
      cs_low = 0;
      repeat (2000) begin
         @(negedge clk);
         if (!CS) cs_low++;
      end
      check("idle_cs_high", cs_low, 0);
      check("idle_no_sample", n_samples - s0, 0);
      enable = 1'b1;
      wait_samples(1, "wait_ch3");
      enable = 1'b0;
      repeat (300) @(negedge clk);

      // Null bit forced on ch 4.
      null_ch = 4;
      enable  = 1'b1;
      wait_samples(2, "wait_ch4_ch5");
      enable  = 1'b0;
      null_ch = -1;
      check("null_err_count", n_null, 1);
`ifdef MCP3008_AVG_EN
      check("bank_ch4_null", int'(ch_data[4]), 545);
`else
      check("bank_ch4_null", int'(ch_data[4]), 500);
`endif
      repeat (300) @(negedge clk);

      // Reset in the middle of ch 6's SHIFT.
      model_val[0] = 10'd1000;
      enable = 1'b1;
      wait_bits(8, "wait_ch6_shift");
      rst_n = 1'b0;
      #1;
      check("rst_mid_cs", int'(CS), 1);
      check("rst_mid_sclk", int'(AD_CLK), 0);
      check("rst_mid_bank", int'(ch_data != '0), 0);
      sb_q.delete();
      exp_ch = 0;
      for (int i = 0; i < 8; i++) begin
         sh_bank[i] = '0;
         sh_seen[i] = 1'b0;
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wait_samples(1, "wait_ch0_after_rst");
      enable = 1'b0;
      check("bank_ch0_first", int'(ch_data[0]), 1000);
      repeat (300) @(negedge clk);

      // Second ch 0 result of 0: averaged or raw.
      model_val[0] = 10'd0;
      enable = 1'b1;
      wait_samples(8, "wait_scan3");
      enable = 1'b0;
`ifdef MCP3008_AVG_EN
      check("bank_ch0_second", int'(ch_data[0]), 500);
`else
      check("bank_ch0_second", int'(ch_data[0]), 0);
`endif
      repeat (300) @(negedge clk);

      check("sb_drain", sb_q.size(), 0);
      check("null_err_total", n_null, 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
